// File: rtl/float_div_ieee_e8_m23_iter_pkg.sv
// Shared constants and types for the iterative single-precision divider.
package float_div_ieee_e8_m23_iter_pkg;

    // Rounding-mode encodings (5-7 fall back to round-to-nearest-even)
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // Bit positions inside the 5-bit flags word {NV, DZ, OF, UF, NX}
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Packed encodings of the special results
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF    = 32'h7F80_0000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

    localparam int EXP_BIAS = 127;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_RND,
        ST_DONE
    } state_t;

    // Apply a sign to an unsigned magnitude encoding
    function automatic logic [31:0] with_sign(input logic s, input logic [31:0] mag);
        return {s, mag[30:0]};
    endfunction

endpackage

// File: rtl/float_div_round_pack.sv
// Normalize the raw restoring quotient, round it, and pack the IEEE result.
module float_div_round_pack
    import float_div_ieee_e8_m23_iter_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  exp_in,
    input  logic [25:0]        q,
    input  logic               rem_nz,
    input  logic [2:0]         rm,
    output logic [31:0]        x,
    output logic [4:0]         flags
);

    logic [23:0]        sig;
    logic               guard;
    logic               sticky;
    logic signed [9:0]  e_norm;
    logic               inc;
    logic [24:0]        sig_rnd;
    logic signed [9:0]  e_rnd;
    logic [23:0]        sig_fin;
    logic               inexact;
    logic               keep_max;

    // Normalize, pick the rounding increment, then classify over/underflow
    always_comb begin
        sig      = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        e_norm   = exp_in;
        inc      = 1'b0;
        keep_max = 1'b0;
        x        = '0;
        flags    = '0;

        // Quotient lies in [2^24, 2^26): the top bit tells which window holds the significand
        if (q[25]) begin
            sig    = q[25:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            e_norm = exp_in;
        end else begin
            sig    = q[24:1];
            guard  = q[0];
            sticky = rem_nz;
            e_norm = exp_in - 10'sd1;
        end

        inexact = guard | sticky;

        case (rm)
            RM_RTZ: begin
                inc      = 1'b0;
                keep_max = 1'b1;
            end
            RM_RDN: begin
                inc      = inexact & sign;
                keep_max = ~sign;
            end
            RM_RUP: begin
                inc      = inexact & ~sign;
                keep_max = sign;
            end
            RM_RMM: inc = guard;
            default: inc = guard & (sticky | sig[0]);
        endcase

        sig_rnd = {1'b0, sig} + {24'd0, inc};
        // A carry out of the significand bumps the exponent and leaves 1.000...
        e_rnd   = e_norm + $signed({9'd0, sig_rnd[24]});
        sig_fin = sig_rnd[24] ? 24'h80_0000 : sig_rnd[23:0];

        if (e_norm <= 10'sd0) begin
            // Flush-to-zero: no subnormal outputs are produced
            x              = {sign, 31'd0};
            flags[FLAG_UF] = 1'b1;
            flags[FLAG_NX] = 1'b1;
        end else if (e_rnd >= 10'sd255) begin
            x              = keep_max ? with_sign(sign, MAX_FINITE) : with_sign(sign, POS_INF);
            flags[FLAG_OF] = 1'b1;
            flags[FLAG_NX] = 1'b1;
        end else begin
            x              = {sign, e_rnd[7:0], sig_fin[22:0]};
            flags[FLAG_NX] = inexact;
        end
    end

endmodule

// File: rtl/float_div_ieee_e8_m23_iter.sv
// Iterative IEEE-754 single-precision divider: one restoring quotient bit per cycle.
module float_div_ieee_e8_m23_iter
    import float_div_ieee_e8_m23_iter_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int QBITS = 26
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             astall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_sign,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [MAN_W-1:0] a_man,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [MAN_W-1:0] b_man,
    input  logic [2:0]       rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      x,
    output logic [4:0]       flags
);

    localparam int CNT_W = $clog2(QBITS);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [24:0]        rem_reg;
    logic [23:0]        div_reg;
    logic [25:0]        q_reg;
    logic signed [9:0]  exp_reg;
    logic               sign_reg;
    logic [2:0]         rm_reg;
    logic [31:0]        x_reg;
    logic [4:0]         flags_reg;
    logic               out_valid_reg;
    logic               in_ready_reg;

    // Per-operand classification; index 0 is the dividend, 1 the divisor
    logic [EXP_W-1:0]   op_exp [2];
    logic [MAN_W-1:0]   op_man [2];
    logic [1:0]         op_zero;
    logic [1:0]         op_inf;
    logic [1:0]         op_nan;

    assign op_exp[0] = a_exp;
    assign op_exp[1] = b_exp;
    assign op_man[0] = a_man;
    assign op_man[1] = b_man;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_class
            // Subnormals (exponent 0) are treated as zero
            assign op_zero[gi] = (op_exp[gi] == '0);
            assign op_inf[gi]  = (op_exp[gi] == '1) && (op_man[gi] == '0);
            assign op_nan[gi]  = (op_exp[gi] == '1) && (op_man[gi] != '0);
        end
    endgenerate

    logic               sign_in;
    logic [9:0]         exp_in;
    logic               spec_hit;
    logic [31:0]        spec_x;
    logic [4:0]         spec_flags;

    assign sign_in = a_sign ^ b_sign;
    assign exp_in  = {2'b00, a_exp} - {2'b00, b_exp} + 10'(EXP_BIAS);

    // Special-operand decode, resolved at accept time
    always_comb begin
        spec_hit   = 1'b1;
        spec_x     = '0;
        spec_flags = '0;
        if ((|op_nan) || (&op_zero) || (&op_inf)) begin
            spec_x              = QNAN;
            spec_flags[FLAG_NV] = 1'b1;
        end else if (op_inf[0]) begin
            spec_x = with_sign(sign_in, POS_INF);
        end else if (op_zero[1]) begin
            spec_x              = with_sign(sign_in, POS_INF);
            spec_flags[FLAG_DZ] = 1'b1;
        end else if (op_zero[0] || op_inf[1]) begin
            spec_x = {sign_in, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic [25:0]        trial;
    logic               q_bit;
    logic [24:0]        rem_kept;
    logic [24:0]        rem_next;
    logic [25:0]        q_next;

    // One restoring step: subtract when it does not go negative, then shift
    always_comb begin
        trial    = {1'b0, rem_reg} - {2'b00, div_reg};
        q_bit    = ~trial[25];
        rem_kept = q_bit ? trial[24:0] : rem_reg;
        // The kept remainder is always below the divisor, so bit 24 is free for the shift
        rem_next = {rem_kept[23:0], 1'b0};
        q_next   = {q_reg[24:0], q_bit};
    end

    logic [31:0]        rnd_x;
    logic [4:0]         rnd_flags;

    float_div_round_pack u_round_pack (
        .sign   (sign_reg),
        .exp_in (exp_reg),
        .q      (q_reg),
        .rem_nz (|rem_reg),
        .rm     (rm_reg),
        .x      (rnd_x),
        .flags  (rnd_flags)
    );

    // Control FSM and iteration datapath; everything freezes while astall is high
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            div_reg       <= '0;
            q_reg         <= '0;
            exp_reg       <= '0;
            sign_reg      <= 1'b0;
            rm_reg        <= '0;
            x_reg         <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else if (!astall) begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_reg     <= sign_in;
                        rm_reg       <= rm;
                        exp_reg      <= $signed(exp_in);
                        rem_reg      <= {2'b01, a_man};
                        div_reg      <= {1'b1, b_man};
                        q_reg        <= '0;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        if (spec_hit) begin
                            x_reg         <= spec_x;
                            flags_reg     <= spec_flags;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end else begin
                            state_reg <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem_reg <= rem_next;
                    q_reg   <= q_next;
                    if (cnt_reg == CNT_W'(QBITS - 1)) begin
                        state_reg <= ST_RND;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RND: begin
                    x_reg         <= rnd_x;
                    flags_reg     <= rnd_flags;
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg & ~astall;
    assign out_valid = out_valid_reg;
    assign x         = x_reg;
    assign flags     = flags_reg;

endmodule

// File: doc/float_div_ieee_e8_m23_iter.md
Name: float_div_ieee_e8_m23_iter

Overview:
- Iterative IEEE-754 single-precision divider, x = a / b. It is the inverse-operation companion to the pipelined E8/M23 multiplier.
- It sits in the SFU datapath beside that multiplier and uses the same split sign/exp/man operand format, the same 3-bit rm, and the same aclk/astall stall convention.
- Unlike the multiplier, it is multi-cycle, so it adds a valid/ready handshake on both sides.
- One restoring-division quotient bit is produced per cycle.

Parameters:
- EXP_W, 8, exponent width (fixed; only value supported).
- MAN_W, 23, stored mantissa width (fixed).
- QBITS, 26, quotient bits computed: 24 significand + 1 guard + 1 normalization.

Ports:
- aclk  in  1  clock, rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- astall  in  1  global stall; while high, all state is frozen.
- in_valid  in  1  operands present.
- in_ready  out  1  divider can accept operands.
- a_sign  in  1  dividend sign.
- a_exp  in  8  dividend biased exponent.
- a_man  in  23  dividend stored mantissa.
- b_sign  in  1  divisor sign.
- b_exp  in  8  divisor biased exponent.
- b_man  in  23  divisor stored mantissa.
- rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN (toward -inf), 3 RUP (toward +inf), 4 RMM; 5-7 treated as RNE.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts the result.
- x  out  32  packed result {sign, exp, man}.
- flags  out  5  {NV, DZ, OF, UF, NX}.

Behaviour:
- Reset (arst_n low, async): state=IDLE, in_ready=1, out_valid=0, x=0, flags=0, all iteration registers cleared. Reset mid-operation discards the operation; no output is produced.
- Stall: while astall=1, nothing changes.
  - No state, counter or datapath register updates.
  - in_ready is forced low.
  - out_valid holds its value, but no transfer occurs.
  - A handshake fires only when !astall.
- States: IDLE, DIV, RND, DONE.
- IDLE: in_ready=1. On accept (in_valid & in_ready), the following are captured:
  - rm and sign = a_sign ^ b_sign.
  - A 24-bit significand with the hidden bit set, for each operand.
  - exp = a_exp - b_exp + 127, held as a 10-bit signed value.
  - Operands with exp=0 are subnormal and are treated as zero (DAZ).
- Special cases at accept: the next state is DONE, so out_valid rises 1 cycle after accept.
  - Either operand NaN, 0/0, or inf/inf: x=0x7FC00000, NV.
  - finite nonzero / 0: x = signed inf, DZ.
  - inf / finite: signed inf, no flags.
  - 0 / nonzero, or finite / inf: signed zero, no flags.
- Normal case: next state is DIV with iteration counter=0.
- DIV: one restoring step per cycle.
  - rem = rem - divisor if that result is non-negative; the quotient bit is 1 in that case.
  - The remainder is shifted left 1 each step.
  - After QBITS=26 cycles (counter 0..25), go to RND.
  - The resulting quotient is q = floor(ma * 2^25 / mb), with q in [2^24, 2^26).
- RND (1 cycle): normalize, then round.
  - If q[25]=1: significand = q[25:2], guard = q[1], sticky = q[0] | (rem != 0).
  - Else: exp -= 1, significand = q[24:1], guard = q[0], sticky = (rem != 0).
  - Rounding:
    - RNE: increment if guard & (sticky | lsb).
    - RMM: increment if guard.
    - RUP: increment if (guard|sticky) & !sign.
    - RDN: increment if (guard|sticky) & sign.
    - RTZ: never increment.
  - Significand carry-out: exp += 1, significand = 0x800000.
  - NX = guard | sticky.
  - Overflow (post-round exp >= 255): OF|NX are set. The result is signed inf, except max-finite 0x7F7FFFFF (sign applied) under RTZ, under RDN for positive results, and under RUP for negative results.
  - Underflow (pre-round normalized exp <= 0): signed zero, UF|NX (flush-to-zero).
  - Go to DONE.
- Latency, accept to out_valid: 28 cycles for normal operands, 1 cycle for specials; astall cycles are added.
- DONE: out_valid=1; x and flags stay stable until out_ready & !astall, then return to IDLE. There is no back-to-back overlap: throughput is one operation per 29+ cycles.
- in_ready=0 in DIV, RND and DONE.

Decomposition:
- Shared package:
  - Rounding-mode encodings RM_RNE..RM_RMM.
  - Flag bit indices.
  - Canonical NaN 0x7FC00000, +inf 0x7F800000, max-finite 0x7F7FFFFF.
  - FSM state enum.
  - Exponent bias 127.
- One sub-module, float_div_round_pack: combinational normalize/round/overflow/underflow/pack. Inputs are sign, 10-bit exp, 26-bit q, rem_nz and rm; outputs are x and flags.
- The FSM, special-case decode and restoring iteration live in the top module.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000, rm=RNE -> x=0x40400000, flags=0, out_valid exactly 28 cycles after accept.
- 1.0/3.0: a=0x3F800000, b=0x40400000 -> RNE gives 0x3EAAAAAB with NX; RTZ gives 0x3EAAAAAA with NX; RUP gives 0x3EAAAAAB.
- Specials:
  - 1.0/0.0 -> 0x7F800000 with DZ.
  - 0/0 -> 0x7FC00000 with NV.
  - -2.0/+inf -> 0x80000000, flags 0.
  - Each produces out_valid 1 cycle after accept.
- Overflow: 0x7F7FFFFF / 0x3F000000 -> RNE gives 0x7F800000 with OF|NX; RTZ gives 0x7F7FFFFF with OF|NX.
- Underflow: 0x00800000 / 0x40000000 (exp=0) -> 0x00000000 with UF|NX.
- Control:
  - astall high for 5 cycles starting at cycle 10 of 6.0/2.0: result appears at cycle 33 and equals 0x40400000.
  - out_ready held low 4 cycles: x stays stable and in_ready stays 0.
  - arst_n pulsed low at cycle 12: out_valid=0, in_ready=1, and a subsequent operation completes correctly.
